word_unpacker: RTL and testbench

- Read-path counterpart of the byte-to-word packer. Pops WORD_WIDTH words (e.g. DDR read data) from the word FIFO.
- Serialises each word into DATA_WIDTH bytes and pushes them into the byte FIFO feeding the UART transmitter.
- Default byte order is LSB-first: word[7:0] goes out first. This exactly inverts the packer's shift-in order, so a packed word round-trips unchanged.

---
 rtl/word_unpacker_pkg.sv | 20 ++
 rtl/word_unpacker_if.sv | 29 ++
 rtl/word_unpacker_shreg.sv | 37 +++
 rtl/word_unpacker.sv | 89 ++++++++
 tb/tb_word_unpacker.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/word_unpacker_pkg.sv
// Shared state encoding and sizing helpers for the word-to-byte unpacker.
// Byte order is LSB-first unless WORD_UNPACKER_MSB_FIRST_EN is defined.
package word_unpacker_pkg;

  localparam int unsigned DATA_WIDTH_DFLT = 8;
  localparam int unsigned WORD_WIDTH_DFLT = 128;
  localparam int unsigned BYTES_PER_WORD  = WORD_WIDTH_DFLT / DATA_WIDTH_DFLT;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    SEND    = 2'd2
  } state_t;

  // Counter must hold 0..bytes inclusive.
  function automatic int unsigned cnt_width(input int unsigned bytes);
    return $clog2(bytes + 1);
  endfunction

endpackage

// File: rtl/word_unpacker_if.sv
// Word-FIFO read port and byte-FIFO write port of the unpacker, plus status.
// master = unpacker side, slave = FIFO/environment side.
interface word_unpacker_if
  import word_unpacker_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DFLT,
  parameter int unsigned WORD_WIDTH = WORD_WIDTH_DFLT
);
  localparam int unsigned CNT_W = cnt_width(WORD_WIDTH / DATA_WIDTH);

  logic [WORD_WIDTH-1:0] word_in;
  logic                  word_fifo_empty;
  logic                  word_rd_en;
  logic                  byte_fifo_full;
  logic [DATA_WIDTH-1:0] byte_out;
  logic                  byte_wr_en;
  logic                  busy;
  logic [CNT_W-1:0]      bytes_left;

  modport master (
    input  word_in, word_fifo_empty, byte_fifo_full,
    output word_rd_en, byte_out, byte_wr_en, busy, bytes_left
  );

  modport slave (
    output word_in, word_fifo_empty, byte_fifo_full,
    input  word_rd_en, byte_out, byte_wr_en, busy, bytes_left
  );
endinterface

// File: rtl/word_unpacker_shreg.sv
// Word holding register that presents one byte at a time and shifts it away.
// WORD_UNPACKER_MSB_FIRST_EN selects top-byte-first order instead of LSB-first.
module word_unpacker_shreg #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned WORD_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  shift,
  input  logic [WORD_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] cur_byte
);

  logic [WORD_WIDTH-1:0] sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh <= '0;
    end else if (load) begin
      sh <= din;
    end else if (shift) begin
`ifdef WORD_UNPACKER_MSB_FIRST_EN
      sh <= sh << DATA_WIDTH;
`else
      sh <= sh >> DATA_WIDTH;
`endif
    end
  end

`ifdef WORD_UNPACKER_MSB_FIRST_EN
  assign cur_byte = sh[WORD_WIDTH-1 -: DATA_WIDTH];
`else
  assign cur_byte = sh[DATA_WIDTH-1:0];
`endif

endmodule

// File: rtl/word_unpacker.sv
// Pops words from the word FIFO and serialises each into bytes for the byte FIFO.
// Define WORD_UNPACKER_MSB_FIRST_EN for MSB-first byte order; default is LSB-first.
module word_unpacker
  import word_unpacker_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DFLT,
  parameter int unsigned WORD_WIDTH = WORD_WIDTH_DFLT
) (
  input logic            clk,
  input logic            rst_n,
  word_unpacker_if.master bus
);

  localparam int unsigned BYTES = WORD_WIDTH / DATA_WIDTH;
  localparam int unsigned CNT_W = cnt_width(BYTES);

  generate
    if ((WORD_WIDTH % DATA_WIDTH) != 0 || WORD_WIDTH < DATA_WIDTH) begin : g_width_check
      $error("word_unpacker: WORD_WIDTH must be a nonzero multiple of DATA_WIDTH");
    end
  endgenerate

  state_t                state;
  state_t                state_nxt;
  logic [CNT_W-1:0]      cnt;
  logic                  rd_c;
  logic                  wr_c;
  logic                  load_c;
  logic [DATA_WIDTH-1:0] byte_c;
  logic [DATA_WIDTH-1:0] cur_byte;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // A word is fetched only from IDLE, so a read never overlaps the last byte.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!bus.word_fifo_empty) state_nxt = CAPTURE;
      CAPTURE: state_nxt = SEND;
      SEND:    if (!bus.byte_fifo_full && cnt == CNT_W'(1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_c   = 1'b0;
    wr_c   = 1'b0;
    load_c = 1'b0;
    byte_c = '0;
    case (state)
      IDLE:    rd_c = !bus.word_fifo_empty;
      CAPTURE: load_c = 1'b1;
      SEND: begin
        wr_c   = !bus.byte_fifo_full;
        byte_c = cur_byte;
      end
      default: ;
    endcase
  end

  // Bytes remaining in the held word; a stalled cycle leaves it unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cnt <= '0;
    else if (load_c) cnt <= CNT_W'(BYTES);
    else if (wr_c)   cnt <= cnt - CNT_W'(1);
  end

  word_unpacker_shreg #(
    .DATA_WIDTH (DATA_WIDTH),
    .WORD_WIDTH (WORD_WIDTH)
  ) u_shreg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load_c),
    .shift    (wr_c),
    .din      (bus.word_in),
    .cur_byte (cur_byte)
  );

  assign bus.word_rd_en = rd_c;
  assign bus.byte_wr_en = wr_c;
  assign bus.byte_out   = byte_c;
  assign bus.busy       = (state != IDLE);
  assign bus.bytes_left = cnt;

endmodule

// File: tb/tb_word_unpacker.sv
// Self-checking bench for word_unpacker: cycle tables, scoreboard and corner-case sequences.
// Honours WORD_UNPACKER_MSB_FIRST_EN for the expected byte order.
module tb_word_unpacker;
  import word_unpacker_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned WW = 128;
  localparam int unsigned NB = WW / DW;
  localparam int unsigned CW = cnt_width(NB);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  word_unpacker_if #(.DATA_WIDTH(DW), .WORD_WIDTH(WW)) bus ();

  word_unpacker #(.DATA_WIDTH(DW), .WORD_WIDTH(WW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int unsigned    scen;
    logic           full;
    logic           exp_rd;
    logic           exp_wr;
    logic [DW-1:0]  exp_byte;
    logic           exp_busy;
    logic [CW-1:0]  exp_left;
  } vec_t;

  vec_t          tbl[$];
  logic [WW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  int unsigned   rd_cyc[$];
  int unsigned   cyc, wr_cnt, last_wr, n_chk, n_pass;
  logic          rd_prev, rst_drive;

  localparam logic [WW-1:0] W_A = 128'h0F0E0D0C_0B0A0908_07060504_03020100;

  function automatic logic [DW-1:0] nth_byte(input logic [WW-1:0] w, input int unsigned k);
`ifdef WORD_UNPACKER_MSB_FIRST_EN
    return w[(NB-1-k)*DW +: DW];
`else
    return w[k*DW +: DW];
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push_word(input logic [WW-1:0] w);
    fifo_q.push_back(w);
    for (int k = 0; k < int'(NB); k++) exp_q.push_back(nth_byte(w, k));
  endtask

  // One clock: model FIFO effects after the edge, then sample at the falling edge.
  task automatic cycle(input logic full_i);
    @(posedge clk);
    #1;
    rst_n = rst_drive;
    if (rd_prev) begin
      check("fifo_underflow", 32'(fifo_q.size() != 0), 32'd1);
      if (fifo_q.size() != 0) bus.word_in = fifo_q.pop_front();
    end
    bus.word_fifo_empty = (fifo_q.size() == 0);
    bus.byte_fifo_full  = full_i;
    @(negedge clk);
    cyc++;
    if (bus.word_fifo_empty) check("rd_while_empty", 32'(bus.word_rd_en), 32'd0);
    if (bus.word_rd_en) rd_cyc.push_back(cyc);
    if (bus.byte_wr_en) begin
      wr_cnt++;
      last_wr = cyc;
      check("sb_byte_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("sb_byte_value", 32'(bus.byte_out), 32'(exp_q.pop_front()));
    end
    rd_prev = bus.word_rd_en;
  endtask

  // Expected cycle-by-cycle trace for one word, optionally stalled at byte stall_k.
  task automatic fill(input int unsigned scen, input logic [WW-1:0] w,
                      input int unsigned stall_k, input int unsigned stall_n);
    vec_t v;
    int unsigned k, stalls;
    v.scen = scen; v.full = 1'b0; v.exp_rd = 1'b1; v.exp_wr = 1'b0;
    v.exp_byte = '0; v.exp_busy = 1'b0; v.exp_left = '0;
    tbl.push_back(v);
    v.exp_rd = 1'b0; v.exp_busy = 1'b1;
    tbl.push_back(v);
    k = 0; stalls = 0;
    while (k < NB) begin
      v.full     = (k == stall_k) && (stalls < stall_n);
      v.exp_wr   = !v.full;
      v.exp_byte = nth_byte(w, k);
      v.exp_left = CW'(NB - k);
      tbl.push_back(v);
      if (v.full) stalls++;
      else        k++;
    end
    v.full = 1'b0; v.exp_wr = 1'b0; v.exp_byte = '0; v.exp_busy = 1'b0; v.exp_left = '0;
    tbl.push_back(v);
  endtask

  task automatic run_scen(input int unsigned scen, input logic [WW-1:0] w, output int unsigned t0);
    bit first;
    first = 1'b1;
    t0 = 0;
    push_word(w);
    foreach (tbl[i]) begin
      if (tbl[i].scen == scen) begin
        cycle(tbl[i].full);
        if (first) begin t0 = cyc; first = 1'b0; end
        check($sformatf("s%0d_rd_t%0d", scen, cyc - t0),   32'(bus.word_rd_en), 32'(tbl[i].exp_rd));
        check($sformatf("s%0d_wr_t%0d", scen, cyc - t0),   32'(bus.byte_wr_en), 32'(tbl[i].exp_wr));
        check($sformatf("s%0d_byte_t%0d", scen, cyc - t0), 32'(bus.byte_out),   32'(tbl[i].exp_byte));
        check($sformatf("s%0d_busy_t%0d", scen, cyc - t0), 32'(bus.busy),       32'(tbl[i].exp_busy));
        check($sformatf("s%0d_left_t%0d", scen, cyc - t0), 32'(bus.bytes_left), 32'(tbl[i].exp_left));
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd"},   32'(bus.word_rd_en), 32'd0);
    check({tag, "_wr"},   32'(bus.byte_wr_en), 32'd0);
    check({tag, "_byte"}, 32'(bus.byte_out),   32'd0);
    check({tag, "_busy"}, 32'(bus.busy),       32'd0);
    check({tag, "_left"}, 32'(bus.bytes_left), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    int unsigned t0, wr0;
    logic [WW-1:0] w0, w1;
    bit first;
    n_chk = 0; n_pass = 0; cyc = 0; wr_cnt = 0; last_wr = 0;
    rd_prev = 1'b0; rst_drive = 1'b0; rst_n = 1'b0;
    bus.word_in = '0; bus.word_fifo_empty = 1'b1; bus.byte_fifo_full = 1'b0;

    fill(0, W_A, NB, 0);
    fill(1, W_A, 5, 3);

    #12;
    check_all_zero("reset");
    rst_drive = 1'b1;
    repeat (2) cycle(1'b0);

    // Single word, no backpressure.
    run_scen(0, W_A, t0);
    check("single_drained", 32'(exp_q.size()), 32'd0);
    check("single_last_byte_cycle", last_wr - t0, 32'd17);
    cycle(1'b0);

    // Three-cycle stall while the sixth byte is presented.
    run_scen(1, W_A, t0);
    check("bp_drained", 32'(exp_q.size()), 32'd0);
    check("bp_last_byte_cycle", last_wr - t0, 32'd20);
    cycle(1'b0);

    // Back-to-back words with the FIFO never empty in between.
    w0 = {$urandom(), $urandom(), $urandom(), $urandom()};
    w1 = {$urandom(), $urandom(), $urandom(), $urandom()};
    rd_cyc.delete();
    wr0 = wr_cnt;
    push_word(w0);
    push_word(w1);
    for (int i = 0; i < 60 && (exp_q.size() != 0 || bus.busy); i++) cycle(1'b0);
    check("b2b_drained", 32'(exp_q.size()), 32'd0);
    check("b2b_reads", 32'(rd_cyc.size()), 32'd2);
    if (rd_cyc.size() >= 2) begin
      check("b2b_read_spacing", rd_cyc[1] - rd_cyc[0], 32'd18);
      check("b2b_last_byte_cycle", last_wr - rd_cyc[0], 32'd35);
    end
    check("b2b_byte_count", wr_cnt - wr0, 32'd32);
    cycle(1'b0);

    // Reset after seven bytes of a word, then a fresh word.
    w0 = {$urandom(), $urandom(), $urandom(), $urandom()};
    w1 = {$urandom(), $urandom(), $urandom(), $urandom()};
    wr0 = wr_cnt;
    push_word(w0);
    for (int i = 0; i < 40 && (wr_cnt - wr0) < 7; i++) cycle(1'b0);
    check("rst_pre_bytes", wr_cnt - wr0, 32'd7);
    exp_q.delete();
    rst_drive = 1'b0;
    repeat (3) begin
      cycle(1'b0);
      check_all_zero("rst_mid");
    end
    rst_drive = 1'b1;
    repeat (3) cycle(1'b0);
    check("rst_no_stray_bytes", wr_cnt - wr0, 32'd7);
    push_word(w1);
    first = 1'b1;
    for (int i = 0; i < 40 && (exp_q.size() != 0 || bus.busy); i++) begin
      cycle(1'b0);
      if (bus.byte_wr_en && first) begin
        check("rst_w1_left", 32'(bus.bytes_left), NB);
        first = 1'b0;
      end
    end
    check("rst_w1_drained", 32'(exp_q.size()), 32'd0);
    check("rst_total_bytes", wr_cnt - wr0, 32'd23);

    // Long empty period: nothing moves.
    for (int i = 0; i < 50; i++) begin
      cycle(1'b0);
      check("empty_idle", {29'd0, bus.word_rd_en, bus.byte_wr_en, bus.busy}, 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
